// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg: shared widths, reset PC, flag encodings and FIFO entry types for the fetch controller
package inst_fetch_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h1c00_0000;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic INST_VALID = 1'b1;
  localparam logic INST_INVALID = 1'b0;
  localparam logic BRANCH = 1'b1;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic epoch;
  } inflight_t;
  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } result_t;
endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// fetch_fifo: synchronous FIFO with clear; ports push_i/pop_i/clear_i/data_i in, full_o/empty_o/count_o/head_o out
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign head_o = mem_q[rd_q];
  assign do_pop = pop_i && !empty_o;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (clear_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: IF-stage fetch PC owner; issues sequential fetches, pairs responses with their PC, drops stale ones by epoch
//   branch_flag_i/branch_target_i: redirect from EX; stall_i: decode not ready
//   req_o/req_addr_o/req_ready_i: fetch request handshake; resp_valid_i/resp_data_i: in-order instruction return
//   pc_o/inst_o/inst_valid_o: presented instruction, zero when invalid
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_i,
  input  logic                   stall_i,
  output logic                   req_o,
  output logic [INST_ADDR_W-1:0] req_addr_o,
  input  logic                   req_ready_i,
  input  logic                   resp_valid_i,
  input  logic [INST_W-1:0]      resp_data_i,
  output logic [INST_ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   inst_valid_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic epoch_q, epoch_d;
  logic branch, hs, if_pop, rs_push, rs_pop;
  logic if_full, if_empty, rs_full, rs_empty;
  logic [CW-1:0] if_cnt, rs_cnt;
  logic [CW:0] occ;
  inflight_t if_head;
  result_t rs_head;
  assign branch = branch_flag_i == BRANCH;
  // in-flight requests and buffered results share one credit pool, so a full
  // result FIFO can never be overrun by responses already on their way
  assign occ = {1'b0, if_cnt} + {1'b0, rs_cnt};
  assign req_o = occ < (CW+1)'(DEPTH) && !if_full && !branch;
  assign req_addr_o = fetch_pc_q;
  assign hs = req_o && req_ready_i;
  assign if_pop = resp_valid_i && !if_empty;
  assign rs_push = if_pop && if_head.epoch == epoch_q && !branch && !rs_full;
  assign inst_valid_o = rs_empty ? INST_INVALID : INST_VALID;
  assign rs_pop = inst_valid_o && !stall_i;
  assign pc_o = inst_valid_o ? rs_head.pc : ZERO_WORD;
  assign inst_o = inst_valid_o ? rs_head.inst : ZERO_WORD;
  always_comb begin
    fetch_pc_d = branch ? branch_target_i : hs ? fetch_pc_q + 32'd4 : fetch_pc_q;
    epoch_d = epoch_q ^ branch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      epoch_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      epoch_q <= epoch_d;
    end
  end
  fetch_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_inflight (
    .clk(clk), .rst_n(rst_n), .push_i(hs), .pop_i(if_pop), .clear_i(1'b0),
    .data_i(inflight_t'{pc: fetch_pc_q, epoch: epoch_q}),
    .full_o(if_full), .empty_o(if_empty), .count_o(if_cnt), .head_o(if_head)
  );
  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_result (
    .clk(clk), .rst_n(rst_n), .push_i(rs_push), .pop_i(rs_pop), .clear_i(branch),
    .data_i(result_t'{pc: if_head.pc, inst: resp_data_i}),
    .full_o(rs_full), .empty_o(rs_empty), .count_o(rs_cnt), .head_o(rs_head)
  );
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: memory model plus scoreboard and directed vector table for inst_fetch_ctrl
module tb_inst_fetch_ctrl;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;
  typedef struct {logic [31:0] addr; logic stale;} pend_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {logic st; logic req; logic [31:0] addr; logic vld; logic [31:0] pc;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic branch_flag_i = 1'b0, stall_i = 1'b0, req_ready_i = 1'b0, resp_valid_i = 1'b0;
  logic [31:0] branch_target_i = '0, resp_data_i = '0;
  logic req_o, inst_valid_o;
  logic [31:0] req_addr_o, pc_o, inst_o;
  pend_t pend[$];
  exp_t exp_q[$];
  vec_t tbl[19];
  logic ready = 1'b1, mem_en = 1'b1, bogus = 1'b0;
  logic cur_br = 1'b0, cur_st = 1'b0, model_req = 1'b0, found;
  logic [31:0] cur_tgt = '0, model_pc = RST_PC, hs_addr = '0;
  int hs_cnt = 0, passed = 0, total = 0;

  inst_fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_i(stall_i), .req_o(req_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .pc_o(pc_o), .inst_o(inst_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic st);
    int occ;
    cur_br = br; cur_tgt = tgt; cur_st = st;
    branch_flag_i = br; branch_target_i = tgt; stall_i = st; req_ready_i = ready;
    resp_valid_i = (mem_en && pend.size() != 0) || bogus;
    resp_data_i = pend.size() != 0 ? inst_of(pend[0].addr) : 32'h1234_5678;
    #1;
    occ = pend.size() + exp_q.size();
    model_req = occ < DEPTH && !br;
    check("req_o", req_o, model_req);
    if (model_req && ready) check("req_addr", req_addr_o, model_pc);
    check("inst_valid", inst_valid_o, exp_q.size() != 0);
    check("pc_o", pc_o, exp_q.size() != 0 ? exp_q[0].pc : 32'h0);
    check("inst_o", inst_o, exp_q.size() != 0 ? exp_q[0].inst : 32'h0);
  endtask

  task automatic advance();
    pend_t p;
    if (exp_q.size() != 0 && !cur_st && !cur_br) void'(exp_q.pop_front());
    if (resp_valid_i && pend.size() != 0) begin
      p = pend.pop_front();
      if (!p.stale && !cur_br) exp_q.push_back('{p.addr, inst_of(p.addr)});
    end
    if (cur_br) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
      model_pc = cur_tgt;
    end else if (model_req && ready) begin
      pend.push_back('{model_pc, 1'b0});
      hs_addr = model_pc;
      hs_cnt++;
      model_pc = model_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic br, input logic [31:0] tgt, input logic st);
    drive(br, tgt, st);
    advance();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'h1c00_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 32'h1c00_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h1c00_0008, 1'b1, 32'h1c00_0000};
    tbl[3] = '{1'b0, 1'b1, 32'h1c00_000c, 1'b1, 32'h1c00_0004};
    tbl[4] = '{1'b1, 1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0008};
    tbl[5] = '{1'b1, 1'b1, 32'h1c00_0014, 1'b1, 32'h1c00_0008};
    for (int i = 6; i < 14; i++) tbl[i] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h1c00_0008};
    tbl[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h1c00_0008};
    tbl[15] = '{1'b0, 1'b1, 32'h1c00_0018, 1'b1, 32'h1c00_000c};
    tbl[16] = '{1'b0, 1'b1, 32'h1c00_001c, 1'b1, 32'h1c00_0010};
    tbl[17] = '{1'b0, 1'b1, 32'h1c00_0020, 1'b1, 32'h1c00_0014};
    tbl[18] = '{1'b0, 1'b1, 32'h1c00_0024, 1'b1, 32'h1c00_0018};
    repeat (2) @(negedge clk);
    check("rst_valid", inst_valid_o, 1'b0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_inst", inst_o, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(1'b0, 32'h0, tbl[i].st);
      check("tbl_req", req_o, tbl[i].req);
      if (tbl[i].req) check("tbl_addr", req_addr_o, tbl[i].addr);
      check("tbl_valid", inst_valid_o, tbl[i].vld);
      if (tbl[i].vld) check("tbl_pc", pc_o, tbl[i].pc);
      advance();
    end
    mem_en = 1'b0;
    for (int i = 0; i < 20 && pend.size() < 3; i++) step(1'b0, 32'h0, 1'b0);
    check("br3_inflight", pend.size(), 3);
    drive(1'b1, 32'h1c00_0100, 1'b0);
    check("br3_req_low", req_o, 1'b0);
    advance();
    mem_en = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    check("br3_flush", inst_valid_o, 1'b0);
    advance();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      if (inst_valid_o) begin
        found = 1'b1;
        check("br3_first_pc", pc_o, 32'h1c00_0100);
      end
      advance();
    end
    check("br3_timeout", found, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid_o && pend.size() != 0) begin
        found = 1'b1;
        drive(1'b1, 32'h1c00_0200, 1'b0);
        check("brx_req_low", req_o, 1'b0);
        advance();
        drive(1'b0, 32'h0, 1'b0);
        check("brx_empty", inst_valid_o, 1'b0);
        advance();
      end else step(1'b0, 32'h0, 1'b0);
    end
    check("brx_timeout", found, 1'b1);
    step(1'b1, 32'hFFFF_FFFC, 1'b0);
    hs_cnt = 0;
    for (int i = 0; i < 20 && hs_cnt < 2; i++) step(1'b0, 32'h0, 1'b0);
    check("wrap_addr", hs_addr, 32'h0);
    for (int i = 0; i < 300; i++) begin
      ready = $urandom_range(0, 3) != 0;
      mem_en = $urandom_range(0, 3) != 0;
      step($urandom_range(0, 19) == 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 4) == 0);
    end
    ready = 1'b1;
    mem_en = 1'b1;
    rst_n = 1'b0;
    #1;
    pend.delete();
    exp_q.delete();
    model_pc = RST_PC;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    mem_en = 1'b0;
    step(1'b0, 32'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", inst_valid_o, 1'b0);
    check("mid_rst_pc", pc_o, 32'h0);
    check("mid_rst_inst", inst_o, 32'h0);
    pend.delete();
    exp_q.delete();
    model_pc = RST_PC;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mem_en = 1'b1;
    hs_addr = '0;
    bogus = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    bogus = 1'b0;
    advance();
    check("mid_rst_first_addr", hs_addr, RST_PC);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
